// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the bit-serial datapath cells.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package arith_pkg;

    localparam int MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bit counter only needs to reach width-1; keep at least one bit for width 2.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit full adder used as the serial datapath cell.
// Latency: purely combinational.
// Backpressure: none.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry_out
);

    assign sum       = a ^ b ^ cin;
    assign carry_out = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_full_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, LSB first.
// Latency: out_valid rises WIDTH edges after the accept edge; one result per WIDTH+1 cycles.
// Backpressure: result held in DONE until out_ready; next operands can be taken on the consume edge.
module serial_full_adder
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             bit_sum;
    logic             bit_carry;
    logic             accept;

    full_adder_cell u_cell (
        .a         (a_sr[0]),
        .b         (b_sr[0]),
        .cin       (carry),
        .sum       (bit_sum),
        .carry_out (bit_carry)
    );

    assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state == DONE);
    assign busy      = (state == SHIFT);
    assign sum       = res_sr;
    assign cout      = carry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        a_sr  <= A;
                        b_sr  <= B;
                        carry <= cin;
                        cnt   <= '0;
                        state <= SHIFT;
                    end else if (state == DONE && out_ready) begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    // Sum bits enter at the MSB so the first computed bit ends up at bit 0.
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= {bit_sum, res_sr[WIDTH-1:1]};
                    carry  <= bit_carry;
                    if (cnt == CNT_LAST) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
